// File: rtl/mem_stage_unit.sv
// Memory stage of the 5-stage pipeline.
// Owns the word-addressed data memory, registers the M->W state (including
// the writeback result mux) and stretches aligned memory accesses over
// MEM_LAT cycles by stalling the upstream stages.
//
// Handshake: StallM is the only flow-control signal. While StallM=1 the
// upstream stages hold every *M input stable; the instruction in M commits
// on the first rising edge at which StallM=0 (and reset is low). Edges seen
// with StallM=1 push a bubble into W.
module mem_stage_unit #(
  parameter int DEPTH   = 64,
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWriteM,
  input  logic        MemtoRegM,
  input  logic        RegWriteM,
  input  logic        sracc_selM,
  input  logic [31:0] ALUOutM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] finalRD3M,
  input  logic [4:0]  WriteRegM,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [4:0]  WriteRegW,
  output logic [31:0] ResultW,
  output logic [31:0] ReadDataW,
  output logic        AlignErrW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MEM_LAT) + 1;
  // Multi-cycle accesses only exist when MEM_LAT exceeds one.
  localparam bit MULTI = (MEM_LAT > 1);
  // The IDLE cycle is the first stall cycle, so ACCESS counts the rest down.
  localparam logic [CW-1:0] CNT_START = MULTI ? CW'(MEM_LAT - 2) : '0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // FSM state is kept in plainly named signals so checkers can bind to them.
  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] idx;
  logic          memop;
  logic          misaligned;
  logic          aligned_op;
  logic          stall;
  logic          commit;
  logic [31:0]   mem_rdata;
  logic [31:0]   load_data;
  logic [31:0]   result_next;
  logic          unused_addr_bits;

  // Word index from the byte address; upper address bits alias onto memory.
  assign idx              = ALUOutM[AW+1:2];
  assign unused_addr_bits = ^ALUOutM[31:AW+2];

  assign memop      = MemWriteM | MemtoRegM;
  assign misaligned = memop & (ALUOutM[1:0] != 2'b00);
  assign aligned_op = memop & ~misaligned;

  // Asynchronous read gives the pre-write value for the commit edge.
  assign mem_rdata = mem[idx];
  // Misaligned loads return zero rather than memory contents.
  assign load_data = (MemtoRegM && !misaligned) ? mem_rdata : 32'h0;

  // Writeback mux: third-operand path wins, then load data, then ALU result.
  assign result_next = sracc_selM ? finalRD3M :
                       MemtoRegM  ? load_data :
                                    ALUOutM;

  // State register and latency counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: an aligned access enters ACCESS when it needs more
  // than one cycle; ACCESS leaves once the counter has drained.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (aligned_op && MULTI) begin
          state_next = ACCESS;
          cnt_next   = CNT_START;
        end
      end
      ACCESS: begin
        if (cnt != '0) begin
          cnt_next = cnt - CW'(1);
        end else begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output logic: stall while the access is still in flight; reset forces
  // the stall low so the pipeline is never held during reset.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = aligned_op && MULTI;
      ACCESS:  stall = (cnt != '0);
      default: stall = 1'b0;
    endcase
    if (reset) begin
      stall = 1'b0;
    end
    commit = !reset && !stall;
  end

  assign StallM = stall;

  // Data memory write: once per store, only at the commit edge and only
  // when aligned. Contents survive reset.
  always_ff @(posedge clk) begin
    if (commit && MemWriteM && !misaligned) begin
      mem[idx] <= WriteDataM;
    end
  end

  // M->W register: reset clears, stall edges insert a bubble, otherwise the
  // instruction in M commits.
  always_ff @(posedge clk) begin
    if (reset) begin
      RegWriteW <= 1'b0;
      WriteRegW <= 5'd0;
      ResultW   <= 32'h0;
      ReadDataW <= 32'h0;
      AlignErrW <= 1'b0;
    end else if (stall) begin
      RegWriteW <= 1'b0;
      WriteRegW <= 5'd0;
      AlignErrW <= 1'b0;
    end else begin
      RegWriteW <= RegWriteM & ~misaligned;
      WriteRegW <= WriteRegM;
      ResultW   <= result_next;
      ReadDataW <= load_data;
      AlignErrW <= misaligned;
    end
  end

endmodule
